// File: rtl/uart_time_reporter.sv
// uart_time_reporter
//   Snapshots the watch/stopwatch time on request and streams it as an ASCII
//   frame "<P> HH:MM:SS.CC<EOL>" through a byte-wide uart_tx handshake.
//   P is 'W' (mode=0) or 'S' (mode=1).
//   Each field is shown as two decimal digits; values above 99 show as "99".
//
// Parameters
//   USE_CRLF  : 1 -> EOL is CR,LF ; 0 -> EOL is LF only
//   PREFIX_EN : 1 -> "<P> " leads the frame ; 0 -> frame starts at hours
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req                   report request pulse
//   mode                  0 = watch, 1 = stopwatch
//   hour/min/sec/msec     binary time fields (msec in centiseconds)
//   tx_busy, tx_done      uart_tx status: busy level, byte-complete pulse
//   tx_start, tx_data     uart_tx load pulse and byte (held until tx_done)
//   busy                  frame in progress (snapshot .. last tx_done)
//   done                  one-cycle pulse when a frame has been sent
module uart_time_reporter #(
  parameter bit USE_CRLF  = 1'b1,
  parameter bit PREFIX_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       mode,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [6:0] msec,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned FRAME_LEN = 11 + (PREFIX_EN ? 2 : 0) + (USE_CRLF ? 2 : 1);
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);
  // Byte positions are numbered as in the full frame; without the prefix the
  // index is shifted past the two prefix characters.
  localparam logic [3:0]  POS_OFS   = PREFIX_EN ? 4'd0 : 4'd2;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, NEXT, FIN} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       pending;
  logic [3:0] idx;
  logic [3:0] pos;
  logic [7:0] byte_sel;

  logic       snap_mode;
  logic [4:0] snap_hour;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [6:0] snap_msec;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] ascii_tens(input logic [6:0] v);
    logic [6:0] s;
    s = sat99(v);
    return 8'h30 + 8'(s / 7'd10);
  endfunction

  function automatic logic [7:0] ascii_ones(input logic [6:0] v);
    logic [6:0] s;
    s = sat99(v);
    return 8'h30 + 8'(s % 7'd10);
  endfunction

  // Frame byte for the current index, built from the snapshot only.
  always_comb begin
    pos      = idx + POS_OFS;
    byte_sel = 8'h00;
    case (pos)
      4'd0:    byte_sel = snap_mode ? 8'h53 : 8'h57;
      4'd1:    byte_sel = 8'h20;
      4'd2:    byte_sel = ascii_tens({2'b00, snap_hour});
      4'd3:    byte_sel = ascii_ones({2'b00, snap_hour});
      4'd4:    byte_sel = 8'h3A;
      4'd5:    byte_sel = ascii_tens({1'b0, snap_min});
      4'd6:    byte_sel = ascii_ones({1'b0, snap_min});
      4'd7:    byte_sel = 8'h3A;
      4'd8:    byte_sel = ascii_tens({1'b0, snap_sec});
      4'd9:    byte_sel = ascii_ones({1'b0, snap_sec});
      4'd10:   byte_sel = 8'h2E;
      4'd11:   byte_sel = ascii_tens(snap_msec);
      4'd12:   byte_sel = ascii_ones(snap_msec);
      4'd13:   byte_sel = USE_CRLF ? 8'h0D : 8'h0A;
      4'd14:   byte_sel = 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req || pending) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (!tx_busy) state_nxt = WAIT;
      WAIT:    if (tx_done) state_nxt = NEXT;
      NEXT:    state_nxt = (idx == LAST_IDX) ? FIN : SEND;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      pending  <= 1'b0;
      idx      <= 4'd0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      // Requests arriving outside IDLE (including in FIN) are merged into a
      // single pending frame that starts once the current one is finished.
      if (state == IDLE) pending <= 1'b0;
      else if (req)      pending <= 1'b1;
      case (state)
        LOAD: begin
          busy <= 1'b1;
          idx  <= 4'd0;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= byte_sel;
          end
        end
        NEXT: begin
          if (idx != LAST_IDX) idx <= idx + 4'd1;
        end
        FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Snapshot: frame content is frozen here for the whole frame.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      snap_mode <= mode;
      snap_hour <= hour;
      snap_min  <= min;
      snap_sec  <= sec;
      snap_msec <= msec;
    end
  end

endmodule

// File: tb/tb_uart_time_reporter.sv
// Testbench for uart_time_reporter: table of time snapshots with their ASCII
// text, a byte scoreboard checked at every tx_start, and hand-written
// sequences for mid-frame input change, merged requests, request during the
// final cycle, a long tx_busy stall, reset mid-frame and the LF-only variant.
module tb_uart_time_reporter;

  logic       clk;
  logic       rst;
  logic       req;
  logic       req_b;
  logic       mode;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [6:0] msec;
  logic       tx_busy, tx_done, tx_start, busy, done;
  logic [7:0] tx_data;
  logic       tx_busy_b, tx_done_b, tx_start_b, busy_b, done_b;
  logic [7:0] tx_data_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  bit         force_busy = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] cur_byte = 8'h00;
  int         done_cnt = 0;
  int         done_total = 0;
  int         busy_falls = 0;
  logic       busy_prev = 1'b0;
  int         forced_starts = 0;
  int         starts_a = 0;
  int         cnt_b = 0;
  int         nb_b = 0;
  int         done_b_cnt = 0;

  uart_time_reporter dut (
    .clk(clk), .rst(rst), .req(req), .mode(mode),
    .hour(hour), .min(min), .sec(sec), .msec(msec),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
  );

  uart_time_reporter #(.USE_CRLF(1'b0), .PREFIX_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .mode(mode),
    .hour(hour), .min(min), .sec(sec), .msec(msec),
    .tx_busy(tx_busy_b), .tx_done(tx_done_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // uart_tx model for the main instance, run on the falling edge.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (tx_start) begin
      starts_a++;
      if (force_busy) forced_starts++;
      if (tx_cnt != 0) chk("start_overlap", tx_cnt, 0);
      else begin
        if (exp_a.size() == 0) chk("byte_expected", exp_a.size(), 1);
        else chk("frame_byte", int'(tx_data), int'(exp_a.pop_front()));
        cur_byte = tx_data;
        tx_cnt   = 3;
      end
    end else if (tx_cnt != 0) begin
      chk("tx_data_hold", int'(tx_data), int'(cur_byte));
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        done_total++;
      end
    end
    tx_busy = force_busy || (tx_cnt != 0);
    if (done) done_cnt++;
    if (busy_prev && !busy) busy_falls++;
    busy_prev = busy;
  end

  // uart_tx model for the LF-only instance.
  always @(negedge clk) begin
    tx_done_b = 1'b0;
    if (tx_start_b && cnt_b == 0) begin
      nb_b++;
      if (exp_b.size() == 0) chk("byte_expected_b", exp_b.size(), 1);
      else chk("frame_byte_b", int'(tx_data_b), int'(exp_b.pop_front()));
      cnt_b = 2;
    end else if (cnt_b != 0) begin
      cnt_b--;
      if (cnt_b == 0) tx_done_b = 1'b1;
    end
    tx_busy_b = (cnt_b != 0);
    if (done_b) done_b_cnt++;
  end

  task automatic push_frame(input logic [103:0] txt);
    for (int k = 12; k >= 0; k--) exp_a.push_back(txt[8*k +: 8]);
    exp_a.push_back(8'h0D);
    exp_a.push_back(8'h0A);
  endtask

  task automatic set_time(input logic m, input logic [4:0] h, input logic [5:0] mi,
                          input logic [5:0] s, input logic [6:0] c);
    mode = m; hour = h; min = mi; sec = s; msec = c;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) tick;
    chk("done_count", done_cnt, target);
  endtask

  // One full frame with latency checks on the first three cycles.
  task automatic run_frame(input logic m, input logic [4:0] h, input logic [5:0] mi,
                           input logic [5:0] s, input logic [6:0] c,
                           input logic [103:0] txt, input bit scramble);
    int d0;
    set_time(m, h, mi, s, c);
    push_frame(txt);
    d0  = done_cnt;
    req = 1'b1;
    tick;
    req = 1'b0;
    chk("lat_load_busy", int'(busy), 0);
    chk("lat_load_start", int'(tx_start), 0);
    tick;
    chk("lat_snap_busy", int'(busy), 1);
    chk("lat_snap_start", int'(tx_start), 0);
    if (scramble) set_time(~m, 5'd23, 6'd59, 6'd59, 7'd99);
    tick;
    chk("lat_first_start", int'(tx_start), 1);
    chk("first_byte", int'(tx_data), int'(txt[103:96]));
    wait_done(d0 + 1);
    chk("queue_drained", exp_a.size(), 0);
    chk("idle_busy", int'(busy), 0);
    repeat (4) tick;
    chk("single_done", done_cnt, d0 + 1);
  endtask

  typedef struct {
    logic         m;
    logic [4:0]   h;
    logic [5:0]   mi;
    logic [5:0]   s;
    logic [6:0]   c;
    logic [103:0] txt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int f0;
    int s0;
    int stall_starts;

    vecs[0] = '{1'b0, 5'd12, 6'd34, 6'd56, 7'd78,  "W 12:34:56.78"};
    vecs[1] = '{1'b1, 5'd0,  6'd0,  6'd0,  7'd0,   "S 00:00:00.00"};
    vecs[2] = '{1'b0, 5'd0,  6'd63, 6'd0,  7'd127, "W 00:63:00.99"};
    vecs[3] = '{1'b1, 5'd31, 6'd59, 6'd63, 7'd100, "S 31:59:63.99"};
    vecs[4] = '{1'b0, 5'd9,  6'd10, 6'd19, 7'd9,   "W 09:10:19.09"};

    rst = 1'b1; req = 1'b0; req_b = 1'b0;
    set_time(1'b0, 5'd0, 6'd0, 6'd0, 7'd0);
    repeat (3) tick;
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    tick;

    for (int v = 0; v < 5; v++)
      run_frame(vecs[v].m, vecs[v].h, vecs[v].mi, vecs[v].s, vecs[v].c, vecs[v].txt, 1'b0);

    // Inputs change right after the snapshot; frame must still read zeros.
    run_frame(1'b1, 5'd0, 6'd0, 6'd0, 7'd0, "S 00:00:00.00", 1'b1);

    // Two extra requests during a frame merge into exactly one more frame.
    set_time(1'b0, 5'd12, 6'd34, 6'd56, 7'd78);
    push_frame("W 12:34:56.78");
    push_frame("W 12:34:56.78");
    d0 = done_cnt; f0 = busy_falls;
    req = 1'b1; tick; req = 1'b0;
    repeat (10) tick;
    req = 1'b1; tick; req = 1'b0;
    repeat (30) tick;
    req = 1'b1; tick; req = 1'b0;
    wait_done(d0 + 2);
    repeat (4) tick;
    chk("merged_done", done_cnt, d0 + 2);
    chk("merged_busy_falls", busy_falls, f0 + 2);
    chk("merged_drained", exp_a.size(), 0);

    // Request landing in the FIN cycle starts the next frame right after.
    push_frame("W 12:34:56.78");
    d0 = done_cnt;
    req = 1'b1; tick; req = 1'b0;
    for (int i = 0; i < 3000 && !(tx_done && exp_a.size() == 0); i++) tick;
    chk("last_done_seen", int'(tx_done), 1);
    tick;
    set_time(1'b1, 5'd1, 6'd2, 6'd3, 7'd4);
    push_frame("S 01:02:03.04");
    req = 1'b1; tick; req = 1'b0;
    chk("fin_done", int'(done), 1);
    chk("fin_busy", int'(busy), 0);
    tick;
    chk("fin_idle_busy", int'(busy), 0);
    tick;
    chk("fin_load_busy", int'(busy), 1);
    tick;
    chk("fin_next_start", int'(tx_start), 1);
    chk("fin_next_byte", int'(tx_data), 32'h53);
    wait_done(d0 + 2);
    chk("fin_drained", exp_a.size(), 0);

    // uart_tx busy for 50 cycles: no tx_start until it clears.
    force_busy = 1'b1;
    tick;
    set_time(1'b0, 5'd7, 6'd8, 6'd9, 7'd10);
    push_frame("W 07:08:09.10");
    d0 = done_cnt; s0 = starts_a;
    req = 1'b1; tick; req = 1'b0;
    stall_starts = 0;
    repeat (50) begin
      tick;
      if (tx_start) stall_starts++;
    end
    chk("stall_no_start", stall_starts, 0);
    chk("stall_busy", int'(busy), 1);
    force_busy = 1'b0;
    wait_done(d0 + 1);
    chk("stall_forced_starts", forced_starts, 0);
    chk("stall_byte_count", starts_a - s0, 15);
    chk("stall_drained", exp_a.size(), 0);

    // Reset after the fifth byte completes; partial frame is dropped.
    set_time(1'b1, 5'd12, 6'd34, 6'd56, 7'd78);
    push_frame("S 12:34:56.78");
    d0 = done_cnt; f0 = done_total;
    req = 1'b1; tick; req = 1'b0;
    for (int i = 0; i < 3000 && !(tx_done && done_total - f0 == 5); i++) tick;
    chk("fifth_done_seen", done_total - f0, 5);
    rst = 1'b1;
    tick;
    chk("mid_rst_tx_start", int'(tx_start), 0);
    chk("mid_rst_tx_data", int'(tx_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    rst = 1'b0;
    exp_a.delete();
    s0 = starts_a;
    repeat (20) tick;
    chk("rst_no_resume", starts_a - s0, 0);
    chk("rst_no_done", done_cnt, d0);
    run_frame(1'b0, 5'd12, 6'd34, 6'd56, 7'd78, "W 12:34:56.78", 1'b0);

    // LF-only variant: 14 bytes ending in 0x0A, saturated centiseconds.
    set_time(1'b0, 5'd5, 6'd63, 6'd7, 7'd127);
    begin
      logic [103:0] t;
      t = "W 05:63:07.99";
      for (int k = 12; k >= 0; k--) exp_b.push_back(t[8*k +: 8]);
      exp_b.push_back(8'h0A);
    end
    d0 = done_b_cnt;
    req_b = 1'b1; tick; req_b = 1'b0;
    for (int i = 0; i < 3000 && done_b_cnt == d0; i++) tick;
    chk("lf_done", done_b_cnt, d0 + 1);
    chk("lf_byte_count", nb_b, 14);
    chk("lf_drained", exp_b.size(), 0);
    chk("lf_busy", int'(busy_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
